clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_ch.sv | 62 ++++++
 rtl/clk_div_prog.sv | 49 ++++
 tb/tb_clk_div_prog.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

  localparam int unsigned CNT_W_DEF   = 24;
  localparam int unsigned DEF_DIV_DEF = 2500000;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, divisor, mode, registered clkout and tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             clkout,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d;
  mode_t            m;
  logic             term;

  // Terminal count detect; cnt never exceeds d so equality is sufficient.
  always_comb begin
    term = (cnt == d);
  end

  // Priority: reset, then config write / sync restart, then enabled counting.
  // In pulse mode clkout tracks tick, so it drops whenever tick does.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt    <= '0;
      d      <= CNT_W'(DEF_DIV);
      m      <= MODE_SQUARE;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (load || sync) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
      if (load) begin
        d <= ld_div;
        m <= mode_t'(ld_mode);
      end
    end else if (en) begin
      if (term) begin
        cnt    <= '0;
        tick   <= 1'b1;
        clkout <= (m == MODE_PULSE) ? 1'b1 : ~clkout;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (m == MODE_PULSE) clkout <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      if (m == MODE_PULSE) clkout <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with shared config port and sync.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = CNT_W_DEF,
  parameter  int unsigned DEF_DIV = DEF_DIV_DEF,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  clkout,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] load;

  // Decode the write target; out-of-range channel numbers match nothing.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) load[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clkin   (clkin),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .load    (load[g]),
      .ld_div  (cfg_div),
      .ld_mode (cfg_mode),
      .clkout  (clkout[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: 3 channels, 8-bit counters, default divisor 4.
module tb_clk_div_prog;

  logic       clkin = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic [2:0] clkout;
  logic [2:0] tick;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  clk_div_prog #(
    .N_CH    (3),
    .CNT_W   (8),
    .DEF_DIV (4)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .clkout   (clkout),
    .tick     (tick)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic       sync;
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic       mode;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic r, input logic [2:0] e, input logic s,
                              input logic w, input logic [1:0] c, input logic [7:0] d,
                              input logic m, input logic [2:0] xc, input logic [2:0] xt);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.we = w; v.ch = c; v.div = d; v.mode = m;
    v.exp_clk = xc; v.exp_tick = xt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] e, input logic s, input logic w,
                       input logic [1:0] c, input logic [7:0] d, input logic m);
    rst = r; en = e; sync = s; cfg_we = w; cfg_ch = c; cfg_div = d; cfg_mode = m;
  endtask

  task automatic idle();
    drive(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    step();
    check("reset clkout", 16'(clkout), 16'd0);
    check("reset tick", 16'(tick), 16'd0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Table: reset, default divisor run, then ch1 D=0 square / ch2 D=2 pulse.
    vt[0] = mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000);
    vt[1] = mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int k = 1; k <= 15; k++)
      vt[k+1] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0,
                   (((k / 5) % 2) != 0) ? 3'b111 : 3'b000,
                   ((k % 5) == 0) ? 3'b111 : 3'b000);
    vt[17] = mk(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd0, 1'b0, 3'b101, 3'b000);
    vt[18] = mk(1'b0, 3'b111, 1'b0, 1'b1, 2'd2, 8'd2, 1'b1, 3'b011, 3'b010);
    vt[19] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b010);
    vt[20] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b010);
    vt[21] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b111);
    vt[22] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b010);
    vt[23] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b010);
    vt[24] = mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b110, 3'b110);

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].sync, vt[i].we, vt[i].ch, vt[i].div, vt[i].mode);
      step();
      check($sformatf("vec%0d clkout", i), 16'(clkout), 16'(vt[i].exp_clk));
      check($sformatf("vec%0d tick", i), 16'(tick), 16'(vt[i].exp_tick));
    end

    // en[0] low for 7 cycles with cnt=2 during the high half of clkout[0].
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      en = (e >= 8 && e <= 14) ? 3'b110 : 3'b111;
      step();
      check($sformatf("pause e%0d tick0", e), 16'(tick[0]), 16'(e == 5 || e == 17));
      check($sformatf("pause e%0d clk0", e), 16'(clkout[0]), 16'(e >= 5 && e < 17));
      check($sformatf("pause e%0d tick1", e), 16'(tick[1]), 16'((e % 5) == 0));
    end

    // Write ch0 D=9 on its terminal-count cycle, then an out-of-range write.
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      idle();
      if (e == 5)  drive(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd9, 1'b0);
      if (e == 16) drive(1'b0, 3'b111, 1'b0, 1'b1, 2'd3, 8'd0, 1'b1);
      step();
      check($sformatf("wrtc e%0d tick", e), 16'(tick),
            16'({ {2{(e % 5) == 0}}, (e == 15) }));
      check($sformatf("wrtc e%0d clkout", e), 16'(clkout),
            16'({ {2{((e / 5) % 2) == 1}}, (e >= 15) }));
    end

    // D=3/5/7 channels restarted by sync; ch2 written in the same cycle.
    do_reset();
    drive(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd3, 1'b0);
    step();
    drive(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd5, 1'b0);
    step();
    idle();
    for (int e = 0; e < 4; e++) step();
    check("sync pre clk0", 16'(clkout[0]), 16'd1);
    drive(1'b0, 3'b111, 1'b1, 1'b1, 2'd2, 8'd7, 1'b0);
    step();
    check("sync clkout", 16'(clkout), 16'd0);
    check("sync tick", 16'(tick), 16'd0);
    idle();
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("sync e%0d tick", e), 16'(tick),
            16'({ (e == 8), (e == 6), (e == 4 || e == 8) }));
      check($sformatf("sync e%0d clkout", e), 16'(clkout),
            16'({ (e >= 8), (e >= 6), (e >= 4 && e < 8) }));
    end

    // Reset mid-period with sync and cfg_we also asserted.
    do_reset();
    drive(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd1, 1'b1);
    step();
    idle();
    step();
    step();
    check("rstmix pre tick0", 16'(tick[0]), 16'd1);
    drive(1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 8'd0, 1'b1);
    step();
    check("rstmix clkout", 16'(clkout), 16'd0);
    check("rstmix tick", 16'(tick), 16'd0);
    idle();
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("rstmix e%0d tick", e), 16'(tick), (e == 5) ? 16'd7 : 16'd0);
      check($sformatf("rstmix e%0d clkout", e), 16'(clkout), (e >= 5) ? 16'd7 : 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
